write_crc_gen: RTL and testbench

- Write-path CRC generator for the DDR5 PHY write manager.
- Consumes the manager's CRC tap (o_crc_data / o_crc_enable) and accumulates one CRC-8 per 4-bit DQ nibble lane over a BL16 burst.
- Returns the registered CRC code on the manager's i_crc_code input, in time for the manager to drive the two CRC beats (beats 16/17).

---
 rtl/write_crc_pkg.sv | 28 ++
 rtl/write_crc_gen_if.sv | 14 +
 rtl/write_crc_lane.sv | 29 ++
 rtl/write_crc_gen.sv | 161 ++++++++++++++++
 tb/tb_write_crc_gen.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_crc_pkg.sv
// Shared constants, FSM states and the CRC-8 (x^8+x^2+x+1) byte-fold helper for the write CRC path.
// The fold consumes data8[7] first, matching the MSB-first shift register.
package write_crc_pkg;

    localparam logic [7:0] CRC_POLY        = 8'h07;
    localparam logic [7:0] CRC_SEED        = 8'h00;
    localparam logic [1:0] BL16            = 2'b00;
    localparam int         BEAT_PAIRS_BL16 = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] crc8_fold8(input logic [7:0] crc, input logic [7:0] data8);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ data8[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/write_crc_gen_if.sv
// CRC tap between the write manager (master) and the CRC generator (slave).
// Beat-pair data in, registered per-burst CRC code plus valid/error status out.
interface write_crc_gen_if #(parameter int N = 4);

    logic           crc_enable;
    logic [2*N-1:0] crc_data;
    logic [2*N-1:0] crc_code;
    logic           crc_valid;
    logic           crc_err;

    modport master (output crc_enable, crc_data, input  crc_code, crc_valid, crc_err);
    modport slave  (input  crc_enable, crc_data, output crc_code, crc_valid, crc_err);

endinterface

// File: rtl/write_crc_lane.sv
// Single-lane CRC-8 accumulator: start folds into the seed, fold continues, clear returns to seed.
// o_crc_next is combinational (this cycle's fold result) so the top can register the final CRC with no extra cycle.
module write_crc_lane
    import write_crc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_start,
    input  logic       i_fold,
    input  logic [7:0] i_data8,
    output logic [7:0] o_crc_next
);

    logic [7:0] r_crc;

    assign o_crc_next = crc8_fold8(i_start ? CRC_SEED : r_crc, i_data8);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_crc <= CRC_SEED;
        end else if (i_clr) begin
            r_crc <= CRC_SEED;
        end else if (i_start || i_fold) begin
            r_crc <= o_crc_next;
        end
    end

endmodule

// File: rtl/write_crc_gen.sv
// DDR5 write-path CRC generator: one CRC-8 per DQ nibble over a BL16 burst; code registered one cycle after the 8th beat pair.
// No backpressure (burst gaps raise o_crc_err). Optional WR_CRC_ERR_INJ_EN adds i_crc_inj to invert bit 0 of every lane CRC.
module write_crc_gen
    import write_crc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable,
    input  logic [1:0]      i_burstlength,
`ifdef WR_CRC_ERR_INJ_EN
    input  logic            i_crc_inj,
`endif
    write_crc_gen_if.slave  bus
);

    localparam int         L         = N / 4;
    localparam logic [2:0] LAST_PAIR = 3'(BEAT_PAIRS_BL16 - 1);

    state_t         r_state, w_state_nxt;
    logic [2:0]     r_cnt, w_cnt_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_err, w_err_nxt;
    logic [2*N-1:0] r_code;
    logic [2*N-1:0] w_final;
    logic           w_clr, w_start, w_fold, w_load, w_code_clr;
    logic           w_bl16;

    assign w_bl16 = (i_burstlength == BL16);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_err_nxt   = 1'b0;
        w_clr       = 1'b0;
        w_start     = 1'b0;
        w_fold      = 1'b0;
        w_load      = 1'b0;
        w_code_clr  = 1'b0;
        if (!i_enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
            w_valid_nxt = 1'b0;
            w_clr       = 1'b1;
            w_code_clr  = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.crc_enable) begin
                        w_valid_nxt = 1'b0;
                        if (w_bl16) begin
                            w_start     = 1'b1;
                            w_cnt_nxt   = 3'd1;
                            w_state_nxt = ACCUM;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.crc_enable) begin
                        w_fold = 1'b1;
                        if (r_cnt == LAST_PAIR) begin
                            w_load      = 1'b1;
                            w_valid_nxt = 1'b1;
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = DONE;
                        end else begin
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end else begin
                        // A gap aborts the burst; the partial CRC is never presented.
                        w_err_nxt   = 1'b1;
                        w_clr       = 1'b1;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 3'd0;
                    w_valid_nxt = 1'b0;
                    w_clr       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            if (w_code_clr) begin
                r_code <= '0;
            end else if (w_load) begin
                r_code <= w_final;
            end
        end
    end

`ifdef WR_CRC_ERR_INJ_EN
    logic r_inj;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_inj <= 1'b0;
        end else if (!i_enable) begin
            r_inj <= 1'b0;
        end else if (w_start) begin
            r_inj <= i_crc_inj;
        end
    end
`endif

    for (genvar k = 0; k < L; k++) begin : g_lane
        logic [7:0] w_d8;
        logic [7:0] w_next;
        logic [7:0] w_fin;

        // Even beat first, DQ4k first within a beat; the fold consumes bit 7 first.
        assign w_d8 = {bus.crc_data[4*k],   bus.crc_data[4*k+1],
                       bus.crc_data[4*k+2], bus.crc_data[4*k+3],
                       bus.crc_data[N+4*k],   bus.crc_data[N+4*k+1],
                       bus.crc_data[N+4*k+2], bus.crc_data[N+4*k+3]};

        write_crc_lane u_lane (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_clr      (w_clr),
            .i_start    (w_start),
            .i_fold     (w_fold),
            .i_data8    (w_d8),
            .o_crc_next (w_next)
        );

`ifdef WR_CRC_ERR_INJ_EN
        assign w_fin = w_next ^ {7'd0, r_inj};
`else
        assign w_fin = w_next;
`endif

        assign w_final[4*k +: 4]   = w_fin[3:0];
        assign w_final[N+4*k +: 4] = w_fin[7:4];
    end

    assign bus.crc_code  = r_code;
    assign bus.crc_valid = r_valid;
    assign bus.crc_err   = r_err;

endmodule

// File: tb/tb_write_crc_gen.sv
// Bench for write_crc_gen: an x4 and an x8 instance share stimulus (x4 sees lane 0 of the x8 data);
// a burst-level model computes CRCs by polynomial long division and is compared every cycle.
module tb_write_crc_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  bl;
    logic        crc_en;
    logic [15:0] d16;
`ifdef WR_CRC_ERR_INJ_EN
    logic        inj;
`endif

    int checks = 0;
    int errors = 0;

    write_crc_gen_if #(.N(4)) bus4 ();
    write_crc_gen_if #(.N(8)) bus8 ();

    assign bus4.crc_enable = crc_en;
    assign bus4.crc_data   = {d16[11:8], d16[3:0]};
    assign bus8.crc_enable = crc_en;
    assign bus8.crc_data   = d16;

    write_crc_gen #(.N(4)) dut4 (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_enable      (en),
        .i_burstlength (bl),
`ifdef WR_CRC_ERR_INJ_EN
        .i_crc_inj     (inj),
`endif
        .bus           (bus4.slave)
    );

    write_crc_gen #(.N(8)) dut8 (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_enable      (en),
        .i_burstlength (bl),
`ifdef WR_CRC_ERR_INJ_EN
        .i_crc_inj     (inj),
`endif
        .bus           (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model: collect the 8 beat pairs, then divide the 64-bit message per lane.
    logic [15:0] mq[$];
    bit          in_burst;
    bit          exp_valid;
    bit          exp_err;
    logic [15:0] exp_code;
    bit          m_inj;

    function automatic logic [7:0] ref_crc(input int k);
        logic [71:0] r;
        r = '0;
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < 4; j++) begin
                r[71 - (8*p + j)]     = mq[p][4*k + j];
                r[71 - (8*p + 4 + j)] = mq[p][8 + 4*k + j];
            end
        end
        for (int i = 71; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] c0, c1;
        if (!rst_n) begin
            in_burst  = 0;
            mq.delete();
            exp_valid = 0;
            exp_err   = 0;
            exp_code  = '0;
        end else begin
            exp_err = 0;
            if (!en) begin
                in_burst  = 0;
                mq.delete();
                exp_valid = 0;
                exp_code  = '0;
            end else if (crc_en) begin
                if (!in_burst) begin
                    exp_valid = 0;
                    if (bl != 2'b00) begin
                        exp_err = 1;
                    end else begin
                        in_burst = 1;
                        mq.delete();
                        mq.push_back(d16);
`ifdef WR_CRC_ERR_INJ_EN
                        m_inj = inj;
`else
                        m_inj = 0;
`endif
                    end
                end else begin
                    mq.push_back(d16);
                    if (mq.size() == 8) begin
                        c0 = ref_crc(0) ^ {7'd0, m_inj};
                        c1 = ref_crc(1) ^ {7'd0, m_inj};
                        exp_code  = {c1[7:4], c0[7:4], c1[3:0], c0[3:0]};
                        exp_valid = 1;
                        in_burst  = 0;
                    end
                end
            end else if (in_burst) begin
                exp_err  = 1;
                in_burst = 0;
                mq.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid4", 16'(bus4.crc_valid), 16'(exp_valid));
            chk("err4",   16'(bus4.crc_err),   16'(exp_err));
            chk("valid8", 16'(bus8.crc_valid), 16'(exp_valid));
            chk("err8",   16'(bus8.crc_err),   16'(exp_err));
            if (exp_valid) begin
                chk("code4", 16'(bus4.crc_code), 16'({exp_code[11:8], exp_code[3:0]}));
                chk("code8", bus8.crc_code, exp_code);
            end
        end
    end

    logic [15:0] pat [8];

    task automatic beat(input logic [15:0] d);
        @(posedge clk); #1;
        crc_en = 1'b1;
        d16    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            crc_en = 1'b0;
            d16    = '0;
        end
    endtask

    task automatic burst();
        for (int i = 0; i < 8; i++) beat(pat[i]);
    endtask

    task automatic set_pat(input logic [15:0] last);
        for (int i = 0; i < 7; i++) pat[i] = '0;
        pat[7] = last;
    endtask

    task automatic rand_pat();
        for (int i = 0; i < 8; i++) pat[i] = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; bl = 2'b00; crc_en = 1'b0; d16 = '0;
`ifdef WR_CRC_ERR_INJ_EN
        inj = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(bus4.crc_valid), 16'd0);
        chk("rst_err",   16'(bus4.crc_err),   16'd0);
        chk("rst_code4", 16'(bus4.crc_code),  16'h0000);
        chk("rst_code8", bus8.crc_code,       16'h0000);
        rst_n = 1'b1; en = 1'b1;
        idle(2);

        set_pat(16'h0000); burst(); idle(1);
        chk("zero_valid", 16'(bus4.crc_valid), 16'd1);
        chk("zero_code4", 16'(bus4.crc_code),  16'h0000);

        set_pat(16'h0800); burst(); idle(1);
        chk("dq3_valid", 16'(bus4.crc_valid), 16'd1);
        chk("dq3_code4", 16'(bus4.crc_code),  16'h0007);
        chk("dq3_code8", bus8.crc_code,       16'h0007);
        idle(1);

        set_pat(16'h8000); burst(); idle(1);
        chk("lane1_code8", bus8.crc_code,       16'h0070);
        chk("lane1_code4", 16'(bus4.crc_code),  16'h0000);
        idle(2);

        // Burst gap after 5 beat pairs
        rand_pat();
        for (int i = 0; i < 5; i++) beat(pat[i]);
        idle(2);
        chk("gap_err",   16'(bus4.crc_err),   16'd1);
        chk("gap_valid", 16'(bus4.crc_valid), 16'd0);
        idle(1);
        chk("gap_err_pulse", 16'(bus4.crc_err), 16'd0);
        set_pat(16'h0000); burst(); idle(1);
        chk("post_gap_code4", 16'(bus4.crc_code), 16'h0000);
        chk("post_gap_valid", 16'(bus4.crc_valid), 16'd1);

        // Back-to-back bursts
        rand_pat(); burst();
        rand_pat(); burst();
        idle(1);
        chk("b2b_valid", 16'(bus8.crc_valid), 16'd1);

        // Unsupported burst length from DONE
        bl = 2'b01; beat(16'hFFFF); idle(1);
        chk("bl_err",   16'(bus4.crc_err),   16'd1);
        chk("bl_valid", 16'(bus4.crc_valid), 16'd0);
        bl = 2'b00; idle(1);

        // Burst length change mid-burst is ignored
        rand_pat();
        for (int i = 0; i < 3; i++) beat(pat[i]);
        bl = 2'b10;
        for (int i = 3; i < 8; i++) beat(pat[i]);
        idle(1);
        chk("bl_mid_valid", 16'(bus8.crc_valid), 16'd1);
        bl = 2'b00;

        // Enable drop mid-burst
        rand_pat();
        for (int i = 0; i < 3; i++) beat(pat[i]);
        @(posedge clk); #1;
        en = 1'b0; crc_en = 1'b0;
        @(posedge clk); #1;
        chk("dis_valid", 16'(bus8.crc_valid), 16'd0);
        chk("dis_err",   16'(bus8.crc_err),   16'd0);
        chk("dis_code8", bus8.crc_code,       16'h0000);
        en = 1'b1;
        idle(1);

        // Reset mid-burst after a completed nonzero CRC
        set_pat(16'h0880); burst();
        rand_pat();
        for (int i = 0; i < 4; i++) beat(pat[i]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 16'(bus8.crc_valid), 16'd0);
        chk("arst_code8", bus8.crc_code,       16'h0000);
        chk("arst_code4", 16'(bus4.crc_code),  16'h0000);
        @(posedge clk); #1;
        crc_en = 1'b0; d16 = '0;
        rst_n  = 1'b1;
        idle(1);

        for (int b = 0; b < 6; b++) begin
            rand_pat(); burst();
            idle($urandom_range(0, 2));
        end
        idle(1);

`ifdef WR_CRC_ERR_INJ_EN
        inj = 1'b1;
        set_pat(16'h0800); burst(); idle(1);
        chk("inj_code4", 16'(bus4.crc_code), 16'h0006);
        inj = 1'b0;
        idle(1);
`endif

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
